// File: rtl/ppc_sched.sv
// ppc_sched: round-robin front end that shares one pipelined 32x8 prefix unit among NREQ requesters.
// Each issued vector carries its {id, seq} tag through the ppc sideband, which is checked against a local copy on return.
module ppc_sched #(
    parameter int NREQ     = 4,
    parameter int PIPE_LAT = 6,
    parameter int MAX_OUT  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*256-1:0] req_data,
    output logic [NREQ-1:0]     req_ready,
    input  logic                hold,
    output logic [255:0]        pp_x,
    output logic [31:0]         pp_a,
    output logic [31:0]         pp_b,
    input  logic [255:0]        pp_y,
    input  logic [31:0]         pp_c,
    input  logic [31:0]         pp_d,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [255:0]        rsp_data,
    output logic                busy,
    output logic                err
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int TL = PIPE_LAT - 1;

    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt     [NREQ];
    logic [31:0]     seq;
    logic            iss_v;
    logic [2:0]      iss_id;
    logic            trk_v   [PIPE_LAT];
    logic [2:0]      trk_id  [PIPE_LAT];
    logic [31:0]     trk_seq [PIPE_LAT];

    logic [NREQ-1:0] elig;
    logic            xfer;
    logic [IW-1:0]   gnt;
    logic [2:0]      gnt_id;
    logic [NREQ-1:0] cnt_inc;
    logic [NREQ-1:0] cnt_dec;
    logic            tag_bad;

    // Handshake: requester i hands over req_data[i] in any cycle where req_valid[i] & req_ready[i];
    // req_ready is combinational, at most one bit high, and never depends on the transfer it enables.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++)
            elig[i] = req_valid[i] & ~hold & (cnt[i] < CW'(MAX_OUT));
    end

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        xfer      = 1'b0;
        gnt       = '0;
        req_ready = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!xfer && elig[(int'(ptr) + k) % NREQ]) begin
                xfer = 1'b1;
                gnt  = IW'((int'(ptr) + k) % NREQ);
            end
        end
        if (xfer)
            req_ready[gnt] = 1'b1;
    end

    assign gnt_id = 3'(gnt);
    assign pp_a   = {iss_v, 28'b0, iss_id};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr    <= IW'(NREQ - 1);
            seq    <= '0;
            iss_v  <= 1'b0;
            iss_id <= '0;
            pp_x   <= '0;
            pp_b   <= '0;
        end else if (xfer) begin
            ptr    <= gnt;
            seq    <= seq + 32'd1;
            iss_v  <= 1'b1;
            iss_id <= gnt_id;
            pp_x   <= req_data[int'(gnt)*256 +: 256];
            pp_b   <= seq;
        end else begin
            iss_v  <= 1'b0;
            iss_id <= '0;
            pp_x   <= '0;
            pp_b   <= '0;
        end
    end

    // Tag copy enters one edge after the issue register so the tail lines up with pp_y/pp_c/pp_d.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < PIPE_LAT; k++) begin
                trk_v[k]   <= 1'b0;
                trk_id[k]  <= '0;
                trk_seq[k] <= '0;
            end
        end else begin
            trk_v[0]   <= iss_v;
            trk_id[0]  <= iss_id;
            trk_seq[0] <= pp_b;
            for (int k = 1; k < PIPE_LAT; k++) begin
                trk_v[k]   <= trk_v[k-1];
                trk_id[k]  <= trk_id[k-1];
                trk_seq[k] <= trk_seq[k-1];
            end
        end
    end

    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int i = 0; i < NREQ; i++) begin
            cnt_inc[i] = xfer && (gnt == IW'(i));
            cnt_dec[i] = trk_v[TL] && (trk_id[TL] == 3'(i));
        end
    end

    assign tag_bad = trk_v[TL] &&
                     ((pp_c != {1'b1, 28'b0, trk_id[TL]}) || (pp_d != trk_seq[TL]));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= cnt_dec;
            if (trk_v[TL])
                rsp_data <= pp_y;
            if (tag_bad)
                err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (cnt_inc[i] && !cnt_dec[i] && (cnt[i] != CW'(MAX_OUT)))
                    cnt[i] <= cnt[i] + 1'b1;
                else if (cnt_dec[i] && !cnt_inc[i] && (cnt[i] != '0))
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    always_comb begin
        busy = iss_v;
        for (int k = 0; k < PIPE_LAT; k++)
            busy = busy | trk_v[k];
    end

endmodule

// File: tb/tb_ppc_sched.sv
// Bench for ppc_sched: a behavioural ppc pipe plus a time-stamped transaction model checked every cycle.
// Directed phases pin the model with literal values; a random phase follows.
module tb_ppc_sched;
    localparam int NREQ     = 4;
    localparam int PIPE_LAT = 6;
    localparam int MAX_OUT  = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*256-1:0] req_data = '0;
    logic [NREQ-1:0]     req_ready;
    logic                hold = 1'b0;
    logic [255:0]        pp_x;
    logic [31:0]         pp_a;
    logic [31:0]         pp_b;
    logic [255:0]        pp_y;
    logic [31:0]         pp_c;
    logic [31:0]         pp_d;
    logic [NREQ-1:0]     rsp_valid;
    logic [255:0]        rsp_data;
    logic                busy;
    logic                err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ppc_sched #(.NREQ(NREQ), .PIPE_LAT(PIPE_LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready), .hold(hold),
        .pp_x(pp_x), .pp_a(pp_a), .pp_b(pp_b),
        .pp_y(pp_y), .pp_c(pp_c), .pp_d(pp_d),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .err(err)
    );

    function automatic logic [255:0] prefix(logic [255:0] x);
        logic [255:0] y;
        logic [7:0]   acc;
        acc = 8'd0;
        y   = '0;
        for (int j = 0; j < 32; j++) begin
            acc        = acc + x[8*j +: 8];
            y[8*j +: 8] = acc;
        end
        return y;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Behavioural ppc: PIPE_LAT register stages, shares the scheduler reset.
    logic [255:0] px [PIPE_LAT];
    logic [31:0]  pa [PIPE_LAT];
    logic [31:0]  pb [PIPE_LAT];
    logic         corrupt_en  = 1'b0;
    logic [31:0]  corrupt_seq = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < PIPE_LAT; k++) begin
                px[k] <= '0;
                pa[k] <= '0;
                pb[k] <= '0;
            end
        end else begin
            px[0] <= pp_x;
            pa[0] <= pp_a;
            pb[0] <= pp_b;
            for (int k = 1; k < PIPE_LAT; k++) begin
                px[k] <= px[k-1];
                pa[k] <= pa[k-1];
                pb[k] <= pb[k-1];
            end
        end
    end

    assign pp_y = prefix(px[PIPE_LAT-1]);
    assign pp_c = pa[PIPE_LAT-1];
    assign pp_d = (corrupt_en && pa[PIPE_LAT-1][31] && pb[PIPE_LAT-1] == corrupt_seq)
                  ? 32'h0000_DEAD : pb[PIPE_LAT-1];

    // Reference model: in-flight transactions stamped with the cycle their response must appear.
    typedef struct {
        int           id;
        logic [255:0] data;
        int           due;
        bit           bad;
    } txn_t;

    txn_t            exp_q[$];
    int              m_ptr;
    int              m_cnt [NREQ];
    logic [31:0]     m_seq;
    logic [255:0]    e_x;
    logic [31:0]     e_a;
    logic [31:0]     e_b;
    logic [NREQ-1:0] e_rv;
    logic [255:0]    e_rd;
    logic            e_err;
    int              cyc = 0;

    task automatic model_reset();
        exp_q.delete();
        m_ptr = NREQ - 1;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        m_seq = '0;
        e_x   = '0;
        e_a   = '0;
        e_b   = '0;
        e_rv  = '0;
        e_rd  = '0;
        e_err = 1'b0;
    endtask

    function automatic int model_grant();
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (req_valid[idx] && !hold && m_cnt[idx] < MAX_OUT) return idx;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : compare
        int              g;
        logic [NREQ-1:0] er;
        txn_t            t;
        cyc++;
        if (!rst) begin
            model_reset();
        end else begin
            g  = model_grant();
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            check("req_ready", req_ready, er);
            check("pp_x", pp_x, e_x);
            check("pp_a", pp_a, e_a);
            check("pp_b", pp_b, e_b);
            check("rsp_valid", rsp_valid, e_rv);
            check("rsp_data", rsp_data, e_rd);
            check("busy", busy, exp_q.size() != 0);
            check("err", err, e_err);
            e_rv = '0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc + 1) begin
                t = exp_q.pop_front();
                e_rv[t.id] = 1'b1;
                e_rd = prefix(t.data);
                if (t.bad) e_err = 1'b1;
                m_cnt[t.id]--;
            end
            if (g >= 0) begin
                t.id   = g;
                t.data = req_data[g*256 +: 256];
                t.due  = cyc + PIPE_LAT + 2;
                t.bad  = corrupt_en && (m_seq == corrupt_seq);
                exp_q.push_back(t);
                m_cnt[g]++;
                e_x   = t.data;
                e_a   = {1'b1, 28'b0, 3'(g)};
                e_b   = m_seq;
                m_seq = m_seq + 32'd1;
                m_ptr = g;
            end else begin
                e_x = '0;
                e_a = '0;
                e_b = '0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input logic [NREQ-1:0] v);
        req_valid = v;
        for (int i = 0; i < NREQ; i++)
            for (int w = 0; w < 8; w++)
                req_data[256*i + 32*w +: 32] = $urandom();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        req_valid = '0;
        hold      = 1'b0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        check("idle_timeout", busy, 1'b0);
        step();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        step();
        check("rst_pp_x", pp_x, '0);
        check("rst_pp_a", pp_a, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valid", rsp_valid, '0);
        step();
        rst = 1'b1;
        step();

        // Round robin from reset: grants 0,1,2,3,... and a gapless sequence number.
        for (int k = 0; k < 8; k++) begin
            if (k > 0) check("rr_pp_b", pp_b, 32'(k - 1));
            drive_rand(4'b1111);
            #1 check("rr_grant", req_ready, 4'b0001 << (k % 4));
            step();
        end
        check("rr_pp_b_last", pp_b, 32'd7);
        wait_idle();

        // Single request from a fresh reset with element j = j.
        do_reset();
        step();
        req_valid = 4'b0001;
        for (int j = 0; j < 32; j++) req_data[8*j +: 8] = 8'(j);
        #1 check("single_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        check("single_pp_a", pp_a, 32'h8000_0000);
        check("single_pp_b", pp_b, 32'd0);
        check("single_busy", busy, 1'b1);
        for (int k = 0; k < PIPE_LAT; k++) begin
            step();
            check("single_early_rsp", rsp_valid, '0);
            check("single_busy_mid", busy, 1'b1);
        end
        step();
        check("single_rsp_valid", rsp_valid, 4'b0001);
        check("single_rsp_e0", rsp_data[7:0], 8'd0);
        check("single_rsp_e2", rsp_data[23:16], 8'd3);
        check("single_rsp_e31", rsp_data[255:248], 8'd240);
        check("single_busy_done", busy, 1'b0);
        wait_idle();

        // Outstanding limit on requester 2 alone.
        for (int k = 0; k < 9; k++) begin
            drive_rand(4'b0100);
            #1 check("limit_ready", req_ready, (k < 3 || k == 8) ? 4'b0100 : 4'b0000);
            step();
        end
        wait_idle();

        // hold blocks issue for five cycles; in-flight work keeps draining.
        for (int k = 0; k < 3; k++) begin
            drive_rand(4'b1111);
            step();
        end
        hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_rand(4'b1111);
            if (k > 0) check("hold_no_issue", pp_a, 32'd0);
            #1 check("hold_ready", req_ready, 4'b0000);
            step();
        end
        hold = 1'b0;
        drive_rand(4'b1111);
        #1 check("hold_resume", req_ready != 0, 1'b1);
        step();
        wait_idle();

        // Tag error: one returning vector comes back with a corrupted sideband d.
        check("tag_err_before", err, 1'b0);
        corrupt_seq = m_seq;
        corrupt_en  = 1'b1;
        drive_rand(4'b0010);
        step();
        req_valid = '0;
        for (int k = 0; k < PIPE_LAT; k++) step();
        check("tag_err_not_yet", err, 1'b0);
        step();
        check("tag_rsp_valid", rsp_valid, 4'b0010);
        check("tag_err_set", err, 1'b1);
        repeat (4) step();
        check("tag_err_sticky", err, 1'b1);
        corrupt_en = 1'b0;
        wait_idle();

        // Reset with four vectors in flight.
        for (int k = 0; k < 4; k++) begin
            drive_rand(4'b1111);
            step();
        end
        req_valid = '0;
        #1 rst = 1'b0;
        #1;
        check("mid_rst_pp_x", pp_x, '0);
        check("mid_rst_pp_a", pp_a, '0);
        check("mid_rst_pp_b", pp_b, '0);
        check("mid_rst_rsp_valid", rsp_valid, '0);
        check("mid_rst_rsp_data", rsp_data, '0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_err", err, 1'b0);
        step();
        step();
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            check("mid_rst_no_rsp", rsp_valid, '0);
        end
        drive_rand(4'b1111);
        #1 check("mid_rst_grant0", req_ready, 4'b0001);
        step();
        req_valid = '0;
        check("mid_rst_pp_b0", pp_b, 32'd0);
        check("mid_rst_pp_a0", pp_a, 32'h8000_0000);
        wait_idle();

        // Random traffic; every cycle is checked by the model.
        for (int k = 0; k < 600; k++) begin
            drive_rand(NREQ'($urandom_range(0, (1 << NREQ) - 1)));
            hold = ($urandom_range(0, 7) == 0);
            step();
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppc_sched.md
Name: ppc_sched

Overview:
- Round-robin scheduler that shares one pipelined 32x8-bit parallel-prefix unit (ppc) between NREQ requesters.
- Accepts one 256-bit vector per cycle from the granted requester and drives it into the ppc input.
- Tags each vector through the ppc 32-bit sideband lanes, tracks in-flight work internally, and steers each result back to its originating requester.
- Sits between requester ports and the ppc instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PIPE_LAT, 6, ppc latency in cycles from x/a/b sampled to y/c/d valid.
- MAX_OUT, 3, maximum in-flight vectors per requester (1..PIPE_LAT+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester vector valid.
- req_data  in  NREQ*256  requester i vector in bits [256i+255:256i]; element j is in bits [8j+7:8j].
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- hold  in  1  while high, no new issue; in-flight work completes.
- pp_x  out  256  ppc data input.
- pp_a  out  32  ppc sideband a: bit31 valid, bits[2:0] requester id, others 0.
- pp_b  out  32  ppc sideband b: issue sequence number.
- pp_y  in  256  ppc data output.
- pp_c  in  32  ppc sideband c (delayed a).
- pp_d  in  32  ppc sideband d (delayed b).
- rsp_valid  out  NREQ  one-hot result strobe, one cycle.
- rsp_data  out  256  result vector.
- busy  out  1  any vector issued and not yet returned.
- err  out  1  sticky tag-mismatch flag.

Behaviour:
- Reset (rst=0, asynchronous), all of these go to 0: pp_x, pp_a, pp_b, rsp_valid, rsp_data, busy, err, the sequence counter, the tracking shift register and the per-requester counters. The round-robin pointer resets to NREQ-1, so requester 0 has first priority.
- Reset mid-operation: all in-flight work is dropped and no rsp_valid is produced for it. The ppc shares rst.
- Eligibility: requester i is eligible when req_valid[i]=1, hold=0 and cnt[i]<MAX_OUT.
- Grant: the first eligible index strictly after the pointer, wrapping modulo NREQ. It is combinational. req_ready[i]=1 only for the granted requester.
- Transfer: happens when req_valid[i] & req_ready[i]. On transfer the pointer is set to i.
- Issue register, at the edge after a transfer at cycle t, valid during t+1:
  - pp_x = req_data[i].
  - pp_a = {1'b1, 28'b0, i[2:0]}.
  - pp_b = seq; seq increments by 1 and wraps at 2^32-1 to 0.
- Idle cycle (no transfer): pp_x, pp_a, pp_b are registered to 0.
- Tracking: an internal shift register of PIPE_LAT entries holds {valid, id, seq}. It is loaded with the issued tag and aligned so its tail is valid in the same cycle as the matching pp_y/pp_c/pp_d.
- Return, when the tail is valid:
  - At the next edge, rsp_data = pp_y and rsp_valid = one-hot(tail id).
  - The rsp_valid pulse lasts exactly one cycle.
  - When the tail is invalid, rsp_valid is 0 and rsp_data holds its last value.
- Latency: rsp_valid rises exactly PIPE_LAT+2 cycles after the transfer cycle (8 by default). Back-to-back transfers produce back-to-back responses in issue order.
- Check: when the tail is valid, pp_c must equal {1, 28'b0, id} and pp_d must equal seq. On mismatch err is set at the next edge and held until reset; the response is still delivered. pp_c/pp_d are ignored when the tail is invalid.
- Counters cnt[i], 0..MAX_OUT:
  - +1 on transfer from i.
  - -1 on the response edge for i.
  - Unchanged when both happen in the same cycle.
  - Never underflows or overflows.
- Full: when cnt[i]=MAX_OUT, req_ready[i]=0 even if i is otherwise the round-robin winner; the grant passes to the next eligible requester.
- hold: asserting it blocks a grant in the same cycle. Deasserting it allows a grant in the same cycle.
- busy = OR of tracking valids and the issue-register valid.

Test Plan:
- Single request: after reset, req_valid[0]=1 for one transfer with data element j = j → pp_a=0x80000000 and pp_b=0 in the next cycle; rsp_valid=4'b0001 exactly 8 cycles after the transfer, with rsp_data equal to the ppc prefix of the input; busy high in between.
- Round robin: req_valid=4'b1111 held → grants in order 0,1,2,3,0,…; responses in the same order; pp_b=0,1,2,… with no gaps.
- Outstanding limit: only req 2 valid, MAX_OUT=3 → three transfers on consecutive cycles, then req_ready[2]=0 until the first response; a fourth transfer occurs in that response cycle.
- hold: assert hold for 5 cycles with all requesters valid → no req_ready, no new issue; in-flight responses still arrive; issue resumes in the cycle hold falls.
- Tag error: force pp_d to 0xDEAD on one returning vector → err=1 from the next edge and stays 1; rsp_valid is still delivered.
- Reset mid-flight: pull rst low with 4 vectors in flight → all outputs 0 immediately; no rsp_valid after release; the next grant goes to requester 0 and pp_b restarts at 0.
